// File: rtl/trap_ctrl_pkg.sv
// Shared widths, CSR addresses, cause codes, state encoding and mstatus helpers
// for the trap sequencer.
package trap_ctrl_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned CsrAddrBus = 12;

  localparam logic [CsrAddrBus-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CsrAddrBus-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CsrAddrBus-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CsrAddrBus-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CsrAddrBus-1:0] CSR_MTVAL   = 12'h343;

  localparam logic [RegBus-1:0] CAUSE_EXT     = 32'h8000_000B;
  localparam logic [RegBus-1:0] CAUSE_SOFT    = 32'h8000_0003;
  localparam logic [RegBus-1:0] CAUSE_TIMER   = 32'h8000_0007;
  localparam logic [RegBus-1:0] CAUSE_ECALL   = 32'h0000_000B;
  localparam logic [RegBus-1:0] CAUSE_EBREAK  = 32'h0000_0003;
  localparam logic [RegBus-1:0] CAUSE_ILLEGAL = 32'h0000_0002;

  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned MPIE_BIT = 7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_MEPC   = 3'd1,
    S_W_MCAUSE = 3'd2,
    S_W_MTVAL  = 3'd3,
    S_W_MSTAT  = 3'd4,
    S_T_JUMP   = 3'd5,
    S_R_MSTAT  = 3'd6,
    S_R_JUMP   = 3'd7
  } state_e;

  // Trap entry: stash MIE into MPIE and disable interrupts.
  function automatic logic [RegBus-1:0] mstatus_enter(input logic [RegBus-1:0] v);
    logic [RegBus-1:0] r;
    r           = v;
    r[MPIE_BIT] = v[MIE_BIT];
    r[MIE_BIT]  = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and set MPIE.
  function automatic logic [RegBus-1:0] mstatus_return(input logic [RegBus-1:0] v);
    logic [RegBus-1:0] r;
    r           = v;
    r[MIE_BIT]  = v[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// CSR register-file trap port: write channel from the sequencer plus the
// asynchronous read data for the currently addressed CSR.
interface trap_ctrl_if;
  import trap_ctrl_pkg::*;

  logic                  trap_csr_we_o;
  logic [CsrAddrBus-1:0] trap_csr_addr_o;
  logic [RegBus-1:0]     trap_csr_wdata_o;
  logic [RegBus-1:0]     trap_csr_rdata_i;

  modport master (
    output trap_csr_we_o,
    output trap_csr_addr_o,
    output trap_csr_wdata_o,
    input  trap_csr_rdata_i
  );

  modport slave (
    input  trap_csr_we_o,
    input  trap_csr_addr_o,
    input  trap_csr_wdata_o,
    output trap_csr_rdata_i
  );

endinterface

// File: rtl/trap_cause_enc.sv
// Combinational priority encoder: picks the winning trap source for the
// idex instruction and produces its mcause / mtval values.
module trap_cause_enc
  import trap_ctrl_pkg::*;
(
  input  logic              inst_valid,
  input  logic [RegBus-1:0] pc,
  input  logic [RegBus-1:0] inst,
  input  logic              ecall,
  input  logic              ebreak,
  input  logic              illegal,
  input  logic              mret,
  input  logic              ex_trap,
  input  logic              tcmp_trap,
  input  logic              soft_trap,
  input  logic              mstatus_mie,
  output logic              take,
  output logic              is_mret,
  output logic [RegBus-1:0] cause,
  output logic [RegBus-1:0] tval
);

  // Synchronous events outrank interrupts; interrupts need global MIE.
  always_comb begin
    take    = 1'b0;
    is_mret = 1'b0;
    cause   = '0;
    tval    = '0;
    if (inst_valid) begin
      if (ecall) begin
        take  = 1'b1;
        cause = CAUSE_ECALL;
      end else if (ebreak) begin
        take  = 1'b1;
        cause = CAUSE_EBREAK;
        tval  = pc;
      end else if (illegal) begin
        take  = 1'b1;
        cause = CAUSE_ILLEGAL;
        tval  = inst;
      end else if (mret) begin
        take    = 1'b1;
        is_mret = 1'b1;
      end else if (mstatus_mie) begin
        if (ex_trap) begin
          take  = 1'b1;
          cause = CAUSE_EXT;
        end else if (soft_trap) begin
          take  = 1'b1;
          cause = CAUSE_SOFT;
        end else if (tcmp_trap) begin
          take  = 1'b1;
          cause = CAUSE_TIMER;
        end
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: on a taken trap, writes mepc/mcause/mtval/mstatus through
// the CSR trap port, then redirects the PC; mret restores mstatus and returns.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid_i,
  input  logic [RegBus-1:0] pc_i,
  input  logic [RegBus-1:0] inst_i,
  input  logic              ecall_i,
  input  logic              ebreak_i,
  input  logic              illegal_i,
  input  logic              mret_i,
  input  logic              ex_trap_i,
  input  logic              tcmp_trap_i,
  input  logic              soft_trap_i,
  input  logic              mstatus_mie_i,
  input  logic [RegBus-1:0] mepc_i,
  trap_ctrl_if.master       trap_csr,
  output logic              hold_o,
  output logic              jump_o,
  output logic [RegBus-1:0] jump_addr_o
);

  state_e            state_q;
  state_e            state_d;
  logic [RegBus-1:0] pc_q;
  logic [RegBus-1:0] cause_q;
  logic [RegBus-1:0] tval_q;

  logic              take;
  logic              is_mret;
  logic [RegBus-1:0] cause;
  logic [RegBus-1:0] tval;
  logic              accept;

  trap_cause_enc u_cause_enc (
    .inst_valid  (inst_valid_i),
    .pc          (pc_i),
    .inst        (inst_i),
    .ecall       (ecall_i),
    .ebreak      (ebreak_i),
    .illegal     (illegal_i),
    .mret        (mret_i),
    .ex_trap     (ex_trap_i),
    .tcmp_trap   (tcmp_trap_i),
    .soft_trap   (soft_trap_i),
    .mstatus_mie (mstatus_mie_i),
    .take        (take),
    .is_mret     (is_mret),
    .cause       (cause),
    .tval        (tval)
  );

  // Events are only sampled while idle; anything during a sequence is dropped.
  assign accept = (state_q == S_IDLE) && take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q    <= pc_i;
        cause_q <= cause;
        tval_q  <= tval;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (take) state_d = is_mret ? S_R_MSTAT : S_W_MEPC;
      S_W_MEPC:   state_d = S_W_MCAUSE;
      S_W_MCAUSE: state_d = S_W_MTVAL;
      S_W_MTVAL:  state_d = S_W_MSTAT;
      S_W_MSTAT:  state_d = S_T_JUMP;
      S_T_JUMP:   state_d = S_IDLE;
      S_R_MSTAT:  state_d = S_R_JUMP;
      S_R_JUMP:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // CSR channel and redirect decode; only the mstatus RMW data follows rdata.
  always_comb begin
    trap_csr.trap_csr_we_o    = 1'b0;
    trap_csr.trap_csr_addr_o  = '0;
    trap_csr.trap_csr_wdata_o = '0;
    jump_o                    = 1'b0;
    jump_addr_o               = '0;
    hold_o                    = (state_q != S_IDLE) || take;
    unique case (state_q)
      S_W_MEPC: begin
        trap_csr.trap_csr_we_o    = 1'b1;
        trap_csr.trap_csr_addr_o  = CSR_MEPC;
        trap_csr.trap_csr_wdata_o = pc_q;
      end
      S_W_MCAUSE: begin
        trap_csr.trap_csr_we_o    = 1'b1;
        trap_csr.trap_csr_addr_o  = CSR_MCAUSE;
        trap_csr.trap_csr_wdata_o = cause_q;
      end
      S_W_MTVAL: begin
        trap_csr.trap_csr_we_o    = 1'b1;
        trap_csr.trap_csr_addr_o  = CSR_MTVAL;
        trap_csr.trap_csr_wdata_o = tval_q;
      end
      S_W_MSTAT: begin
        trap_csr.trap_csr_we_o    = 1'b1;
        trap_csr.trap_csr_addr_o  = CSR_MSTATUS;
        trap_csr.trap_csr_wdata_o = mstatus_enter(trap_csr.trap_csr_rdata_i);
      end
      S_T_JUMP: begin
        trap_csr.trap_csr_addr_o  = CSR_MTVEC;
        jump_o                    = 1'b1;
        jump_addr_o               = trap_csr.trap_csr_rdata_i & ~32'h3;
      end
      S_R_MSTAT: begin
        trap_csr.trap_csr_we_o    = 1'b1;
        trap_csr.trap_csr_addr_o  = CSR_MSTATUS;
        trap_csr.trap_csr_wdata_o = mstatus_return(trap_csr.trap_csr_rdata_i);
      end
      S_R_JUMP: begin
        jump_o                    = 1'b1;
        jump_addr_o               = mepc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a small CSR file model answers the trap port,
// a reference model predicts each trap's writes/jump/hold window.
module tb_trap_ctrl;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  localparam int K_NONE = 0, K_ECALL = 1, K_EBREAK = 2, K_ILLEGAL = 3, K_MRET = 4;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid, ecall, ebreak, illegal, mret;
  logic        ex_trap, tcmp_trap, soft_trap;
  logic [31:0] pc, inst;
  logic        hold, jump;
  logic [31:0] jump_addr;

  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mtval;
  logic        poke_v = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [31:0] poke_data = '0;
  logic        w_en;
  logic [11:0] w_addr;
  logic [31:0] w_data;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  exp_t wq[$];
  exp_t jq[$];
  bit   hold_exp[int];

  trap_ctrl_if bus();

  trap_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_valid_i  (inst_valid),
    .pc_i          (pc),
    .inst_i        (inst),
    .ecall_i       (ecall),
    .ebreak_i      (ebreak),
    .illegal_i     (illegal),
    .mret_i        (mret),
    .ex_trap_i     (ex_trap),
    .tcmp_trap_i   (tcmp_trap),
    .soft_trap_i   (soft_trap),
    .mstatus_mie_i (m_mstatus[3]),
    .mepc_i        (m_mepc),
    .trap_csr      (bus),
    .hold_o        (hold),
    .jump_o        (jump),
    .jump_addr_o   (jump_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CSR file model: asynchronous read, write at the clock edge.
  always_comb begin
    case (bus.trap_csr_addr_o)
      A_MSTATUS: bus.trap_csr_rdata_i = m_mstatus;
      A_MTVEC:   bus.trap_csr_rdata_i = m_mtvec;
      A_MEPC:    bus.trap_csr_rdata_i = m_mepc;
      A_MCAUSE:  bus.trap_csr_rdata_i = m_mcause;
      A_MTVAL:   bus.trap_csr_rdata_i = m_mtval;
      default:   bus.trap_csr_rdata_i = 32'h0;
    endcase
  end

  assign w_en   = poke_v | bus.trap_csr_we_o;
  assign w_addr = poke_v ? poke_addr : bus.trap_csr_addr_o;
  assign w_data = poke_v ? poke_data : bus.trap_csr_wdata_o;

  always @(posedge clk) begin
    if (w_en) begin
      case (w_addr)
        A_MSTATUS: m_mstatus <= w_data;
        A_MTVEC:   m_mtvec   <= w_data;
        A_MEPC:    m_mepc    <= w_data;
        A_MCAUSE:  m_mcause  <= w_data;
        A_MTVAL:   m_mtval   <= w_data;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: DUT output with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes a CSR or redirects.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("hold", 32'(hold), 32'(hold_exp.exists(cyc)));
      if (bus.trap_csr_we_o) begin
        if (wq.size() == 0) unexpected("csr_write");
        else begin
          e = wq.pop_front();
          chk("write_cycle", 32'(cyc), 32'(e.cyc));
          chk("write_addr", 32'(bus.trap_csr_addr_o), 32'(e.addr));
          chk("write_data", bus.trap_csr_wdata_o, e.data);
        end
      end
      if (jump) begin
        if (jq.size() == 0) unexpected("jump");
        else begin
          e = jq.pop_front();
          chk("jump_cycle", 32'(cyc), 32'(e.cyc));
          chk("jump_addr", jump_addr, e.data);
        end
      end
    end
  end

  function automatic void push_w(input int c, input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.addr = a; e.data = d;
    wq.push_back(e);
  endfunction

  // Reference model: decides the trap from the current inputs and CSR state,
  // queues the expected CSR traffic and returns the number of busy cycles.
  function automatic int issue();
    int          t;
    bit          trap;
    logic [31:0] cause, tval, ms;
    exp_t        j;
    t = cyc; trap = 1'b0; cause = 32'h0; tval = 32'h0; ms = m_mstatus;
    if (!inst_valid) return 0;
    if (mret) begin
      ms[3] = m_mstatus[7];
      ms[7] = 1'b1;
      push_w(t + 1, A_MSTATUS, ms);
      j.cyc = t + 2; j.addr = 12'h0; j.data = m_mepc;
      jq.push_back(j);
      for (int k = 0; k <= 2; k++) hold_exp[t + k] = 1'b1;
      return 2;
    end
    if (ecall)                begin trap = 1'b1; cause = 32'h0000_000B; end
    else if (ebreak)          begin trap = 1'b1; cause = 32'h0000_0003; tval = pc; end
    else if (illegal)         begin trap = 1'b1; cause = 32'h0000_0002; tval = inst; end
    else if (m_mstatus[3]) begin
      if (ex_trap)            begin trap = 1'b1; cause = 32'h8000_000B; end
      else if (soft_trap)     begin trap = 1'b1; cause = 32'h8000_0003; end
      else if (tcmp_trap)     begin trap = 1'b1; cause = 32'h8000_0007; end
    end
    if (!trap) return 0;
    ms[7] = m_mstatus[3];
    ms[3] = 1'b0;
    push_w(t + 1, A_MEPC, pc);
    push_w(t + 2, A_MCAUSE, cause);
    push_w(t + 3, A_MTVAL, tval);
    push_w(t + 4, A_MSTATUS, ms);
    j.cyc = t + 5; j.addr = 12'h0; j.data = m_mtvec & 32'hFFFF_FFFC;
    jq.push_back(j);
    for (int k = 0; k <= 5; k++) hold_exp[t + k] = 1'b1;
    return 5;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input logic v, input logic [31:0] p, input logic [31:0] i, input int k,
                        input logic e, input logic t, input logic s);
    inst_valid = v; pc = p; inst = i;
    ecall = (k == K_ECALL); ebreak = (k == K_EBREAK);
    illegal = (k == K_ILLEGAL); mret = (k == K_MRET);
    ex_trap = e; tcmp_trap = t; soft_trap = s;
  endtask

  task automatic clr_in();
    set_ev(1'b0, 32'h0, 32'h0, K_NONE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic junk();
    set_ev(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 4)),
           1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    poke_addr = a; poke_data = d; poke_v = 1'b1;
    step();
    poke_v = 1'b0;
  endtask

  // Inputs for this cycle are already driven; junk is applied while busy.
  task automatic fire();
    int n;
    n = issue();
    for (int k = 0; k < n; k++) begin
      step();
      junk();
    end
    step();
    clr_in();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_hold"}, 32'(hold), 32'h0);
    chk({tag, "_jump"}, 32'(jump), 32'h0);
    chk({tag, "_jump_addr"}, jump_addr, 32'h0);
    chk({tag, "_we"}, 32'(bus.trap_csr_we_o), 32'h0);
    chk({tag, "_addr"}, 32'(bus.trap_csr_addr_o), 32'h0);
    chk({tag, "_wdata"}, bus.trap_csr_wdata_o, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    m_mstatus = 32'h0; m_mtvec = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;

    // ecall with MIE set
    poke(A_MTVEC, 32'h0000_00D8);
    poke(A_MSTATUS, 32'h0000_0008);
    set_ev(1'b1, 32'h100, 32'h0000_0073, K_ECALL, 1'b0, 1'b0, 1'b0);
    fire();
    chk("ecall_mepc", m_mepc, 32'h100);
    chk("ecall_mcause", m_mcause, 32'hB);
    chk("ecall_mtval", m_mtval, 32'h0);
    chk("ecall_mstatus", m_mstatus, 32'h80);

    // simultaneous interrupts: external wins, then software
    poke(A_MSTATUS, 32'h0000_0008);
    set_ev(1'b1, 32'h140, 32'h0, K_NONE, 1'b1, 1'b1, 1'b1);
    fire();
    chk("irq_ext_mcause", m_mcause, 32'h8000_000B);
    poke(A_MSTATUS, 32'h0000_0008);
    set_ev(1'b1, 32'h144, 32'h0, K_NONE, 1'b0, 1'b1, 1'b1);
    fire();
    chk("irq_soft_mcause", m_mcause, 32'h8000_0003);

    // masked timer, then unmasked
    poke(A_MSTATUS, 32'h0000_0000);
    for (int k = 0; k < 3; k++) begin
      set_ev(1'b1, 32'h180, 32'h0, K_NONE, 1'b0, 1'b1, 1'b0);
      fire();
    end
    chk("masked_mcause", m_mcause, 32'h8000_0003);
    poke(A_MSTATUS, 32'h0000_0008);
    set_ev(1'b1, 32'h180, 32'h0, K_NONE, 1'b0, 1'b1, 1'b0);
    fire();
    chk("timer_mcause", m_mcause, 32'h8000_0007);

    // illegal beats a pending external interrupt
    poke(A_MSTATUS, 32'h0000_0008);
    set_ev(1'b1, 32'h200, 32'hFFFF_FFFF, K_ILLEGAL, 1'b1, 1'b0, 1'b0);
    fire();
    chk("illegal_mcause", m_mcause, 32'h2);
    chk("illegal_mtval", m_mtval, 32'hFFFF_FFFF);
    chk("illegal_mepc", m_mepc, 32'h200);

    // mret
    poke(A_MSTATUS, 32'h0000_0080);
    poke(A_MEPC, 32'h0000_0104);
    set_ev(1'b1, 32'h300, 32'h3020_0073, K_MRET, 1'b0, 1'b0, 1'b0);
    fire();
    chk("mret_mstatus", m_mstatus, 32'h88);

    // reset in the middle of an ecall sequence
    poke(A_MSTATUS, 32'h0000_0008);
    mon_en = 1'b0;
    set_ev(1'b1, 32'h400, 32'h0000_0073, K_ECALL, 1'b0, 1'b0, 1'b0);
    step();
    clr_in();
    step();
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    chk("midreset_mepc", m_mepc, 32'h400);
    chk("midreset_mstatus", m_mstatus, 32'h8);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    set_ev(1'b1, 32'h500, 32'h0000_0073, K_ECALL, 1'b0, 1'b0, 1'b0);
    fire();
    chk("post_reset_mepc", m_mepc, 32'h500);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) poke(A_MSTATUS, $urandom);
      if ($urandom_range(0, 5) == 0) poke(A_MTVEC, $urandom);
      if ($urandom_range(0, 5) == 0) poke(A_MEPC, $urandom);
      set_ev(1'($urandom_range(0, 4) != 0), $urandom, $urandom, int'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), 1'($urandom));
      fire();
    end

    step();
    chk("writes_left", 32'(wq.size()), 32'h0);
    chk("jumps_left", 32'(jq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
